// File: rtl/cikis_cerceveleyici_pkg.sv
// Shared definitions for the output framer: FSM state encoding, checksum width
// and header length. Also used by the RX side (saglama_toplayici reuse).
package cikis_cerceveleyici_pkg;

    localparam int CERCEVE_TOPLAM_BIT = 8;
    localparam int BASLIK_UZUNLUK     = 2;

    typedef enum logic [2:0] {
        BOSTA    = 3'd0,
        BASLIK_H = 3'd1,
        BASLIK_L = 3'd2,
        VERI     = 3'd3,
        TOPLAM   = 3'd4,
        BITTI    = 3'd5
    } durum_t;

endpackage

// File: rtl/cikis_cerceveleyici_saglama_toplayici.sv
// saglama_toplayici: 8-bit wrap-around accumulator with synchronous clear and
// add-enable; clear wins over add.
module saglama_toplayici
    import cikis_cerceveleyici_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          temizle_i,
    input  logic                          ekle_i,
    input  logic [CERCEVE_TOPLAM_BIT-1:0] veri_i,
    output logic [CERCEVE_TOPLAM_BIT-1:0] toplam_o
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            toplam_o <= '0;
        end else if (temizle_i) begin
            toplam_o <= '0;
        end else if (ekle_i) begin
            toplam_o <= toplam_o + veri_i;
        end
    end

endmodule

// File: rtl/cikis_cerceveleyici.sv
// Output framer: passes N pixels to the TX FIFO and appends an 8-bit checksum.
// Define CERCEVE_BASLIK_EN to prepend a 2-byte big-endian length header.
module cikis_cerceveleyici
    import cikis_cerceveleyici_pkg::*;
#(
    parameter int VERI_BIT  = 8,
    parameter int SAYAC_BIT = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 basla_i,
    input  logic [SAYAC_BIT-1:0] piksel_sayisi_i,
    input  logic [VERI_BIT-1:0]  veri_i,
    input  logic                 gecerli_i,
    output logic                 stall_o,
    output logic [VERI_BIT-1:0]  veri_o,
    output logic                 gecerli_o,
    input  logic                 dolu_i,
    output logic                 mesgul_o,
    output logic                 bitti_o
);

    durum_t                durum_q, durum_d;
    logic [SAYAC_BIT-1:0]  kalan_q;
    logic [VERI_BIT-1:0]   toplam;
    logic                  yukle;
    logic                  tuket;

    saglama_toplayici u_toplayici (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .temizle_i (yukle),
        .ekle_i    (tuket),
        .veri_i    (veri_i),
        .toplam_o  (toplam)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q <= BOSTA;
            kalan_q <= '0;
        end else begin
            durum_q <= durum_d;
            if (yukle) begin
                kalan_q <= piksel_sayisi_i;
            end else if (tuket) begin
                kalan_q <= kalan_q - SAYAC_BIT'(1);
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        durum_d   = durum_q;
        gecerli_o = 1'b0;
        veri_o    = '0;
        yukle     = 1'b0;
        tuket     = 1'b0;

        case (durum_q)
            BOSTA: begin
                if (basla_i) begin
                    yukle = 1'b1;
`ifdef CERCEVE_BASLIK_EN
                    durum_d = BASLIK_H;
`else
                    durum_d = (piksel_sayisi_i == '0) ? TOPLAM : VERI;
`endif
                end
            end
`ifdef CERCEVE_BASLIK_EN
            // Header bytes come from the latched count, which is untouched
            // until the first pixel is consumed.
            BASLIK_H: begin
                if (!dolu_i) begin
                    gecerli_o = 1'b1;
                    veri_o    = kalan_q[15:8];
                    durum_d   = BASLIK_L;
                end
            end
            BASLIK_L: begin
                if (!dolu_i) begin
                    gecerli_o = 1'b1;
                    veri_o    = kalan_q[7:0];
                    durum_d   = (kalan_q == '0) ? TOPLAM : VERI;
                end
            end
`endif
            VERI: begin
                if (gecerli_i && !dolu_i) begin
                    tuket     = 1'b1;
                    gecerli_o = 1'b1;
                    veri_o    = veri_i;
                    if (kalan_q == SAYAC_BIT'(1)) begin
                        durum_d = TOPLAM;
                    end
                end
            end
            TOPLAM: begin
                if (!dolu_i) begin
                    gecerli_o = 1'b1;
                    veri_o    = toplam;
                    durum_d   = BITTI;
                end
            end
            BITTI: begin
                durum_d = BOSTA;
            end
            default: begin
                durum_d = BOSTA;
            end
        endcase
    end

    // Outside VERI the task unit is always held, so surplus pixels wait.
    assign stall_o  = dolu_i || (durum_q != VERI);
    assign mesgul_o = (durum_q != BOSTA);
    assign bitti_o  = (durum_q == BITTI);

endmodule

// File: tb/tb_cikis_cerceveleyici.sv
// Directed scoreboard bench for cikis_cerceveleyici; follows CERCEVE_BASLIK_EN
// when the macro is defined for the build.
module tb_cikis_cerceveleyici;

`ifdef CERCEVE_BASLIK_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        basla_i = 1'b0;
    logic [15:0] piksel_sayisi_i = '0;
    logic [7:0]  veri_i = '0;
    logic        gecerli_i = 1'b0;
    logic        stall_o;
    logic [7:0]  veri_o;
    logic        gecerli_o;
    logic        dolu_i = 1'b0;
    logic        mesgul_o;
    logic        bitti_o;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pix[8];

    cikis_cerceveleyici dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .basla_i         (basla_i),
        .piksel_sayisi_i (piksel_sayisi_i),
        .veri_i          (veri_i),
        .gecerli_i       (gecerli_i),
        .stall_o         (stall_o),
        .veri_o          (veri_o),
        .gecerli_o       (gecerli_o),
        .dolu_i          (dolu_i),
        .mesgul_o        (mesgul_o),
        .bitti_o         (bitti_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every FIFO write is popped against the expected byte stream.
    always @(negedge clk_i) begin
        if (rstn_i) begin
            if (gecerli_o) begin
                writes++;
                check("write_while_full", 32'(dolu_i), 32'd0);
                if (exp_q.size() == 0) check("unexpected_write", 32'(veri_o), 32'h100);
                else check("byte", 32'(veri_o), 32'(exp_q.pop_front()));
            end else begin
                check("idle_data_zero", 32'(veri_o), 32'd0);
            end
        end
    end

    task automatic frame(input int n, input int dolu_at, input int dolu_len,
                         input int basla_at, input bit surplus);
        logic [7:0] sum;
        int idx, bitti_cnt, bitti_cyc, done_cyc, w0;
        sum = 8'h00; idx = 0; bitti_cnt = 0; bitti_cyc = -1; done_cyc = -1;
        if (HDR != 0) begin
            exp_q.push_back(8'(n >> 8));
            exp_q.push_back(8'(n));
        end
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(pix[i]);
            sum = sum + pix[i];
        end
        exp_q.push_back(sum);
        w0 = writes;

        basla_i = 1'b1; piksel_sayisi_i = 16'(n); gecerli_i = 1'b0; dolu_i = 1'b0;
        @(posedge clk_i); #1;
        basla_i = 1'b0;
        for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
            dolu_i          = (cyc >= dolu_at) && (cyc < dolu_at + dolu_len);
            basla_i         = (cyc == basla_at);
            piksel_sayisi_i = basla_i ? 16'd9 : 16'(n);
            gecerli_i       = (idx < n) || surplus;
            veri_i          = (idx < n) ? pix[idx] : 8'h55;
            @(negedge clk_i);
            if (dolu_i) check("stall_while_full", 32'(stall_o), 32'd1);
            if (idx >= n && gecerli_i) check("surplus_stalled", 32'(stall_o), 32'd1);
            if (gecerli_i && !stall_o) idx++;
            if (bitti_o) begin
                bitti_cnt++;
                bitti_cyc = cyc;
            end
            if (!mesgul_o) done_cyc = cyc;
            @(posedge clk_i); #1;
        end
        basla_i = 1'b0; gecerli_i = 1'b0; dolu_i = 1'b0;

        check("frame_done", 32'(done_cyc > 0), 32'd1);
        check("bitti_pulses", 32'(bitti_cnt), 32'd1);
        check("consumed", 32'(idx), 32'(n));
        check("write_count", 32'(writes - w0), 32'(n + 1 + HDR));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        if (dolu_len == 0) begin
            check("bitti_cycle", 32'(bitti_cyc), 32'(n + 2 + HDR));
            check("idle_cycle", 32'(done_cyc), 32'(n + 3 + HDR));
        end
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        #3;
        check("rst_stall", 32'(stall_o), 32'd1);
        check("rst_gecerli", 32'(gecerli_o), 32'd0);
        check("rst_veri", 32'(veri_o), 32'd0);
        check("rst_mesgul", 32'(mesgul_o), 32'd0);
        check("rst_bitti", 32'(bitti_o), 32'd0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;
        @(posedge clk_i); #1;

        // Basic frame, checksum wraps: 0x10+0x20+0xF0 = 0x120 -> 0x20
        pix = '{8'h10, 8'h20, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        frame(3, 0, 0, 0, 1'b0);

        // FIFO full for 3 cycles mid-frame; checksum 4*0xFF -> 0xFC
        pix = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        frame(4, 2, 3, 0, 1'b0);

        // Empty frame: only checksum 0x00 (plus header when enabled)
        frame(0, 0, 0, 0, 1'b0);

        // Surplus 0x55 held stalled, and a start pulse mid-frame is ignored
        pix = '{8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        frame(2, 0, 0, 2, 1'b1);

        // Full during checksum and header phase
        pix = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        frame(2, 1, 2, 0, 1'b0);
        frame(2, 3 + HDR, 2, 0, 1'b0);

        // Reset after the first of five pixels
        if (HDR != 0) begin
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h05);
        end
        exp_q.push_back(8'hA1);
        basla_i = 1'b1; piksel_sayisi_i = 16'd5;
        @(posedge clk_i); #1;
        basla_i = 1'b0; gecerli_i = 1'b1; veri_i = 8'hA1;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk_i);
            if (!stall_o) got = 1;
            @(posedge clk_i); #1;
        end
        check("pre_reset_consumed", 32'(got), 32'd1);
        rstn_i = 1'b0;
        #1;
        check("midrst_stall", 32'(stall_o), 32'd1);
        check("midrst_gecerli", 32'(gecerli_o), 32'd0);
        check("midrst_veri", 32'(veri_o), 32'd0);
        check("midrst_mesgul", 32'(mesgul_o), 32'd0);
        check("midrst_bitti", 32'(bitti_o), 32'd0);
        check("midrst_queue", 32'(exp_q.size()), 32'd0);
        gecerli_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        @(posedge clk_i); #1;
        check("post_rst_idle", 32'(mesgul_o), 32'd0);

        pix = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        frame(1, 0, 0, 0, 1'b0);

        repeat (3) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
